// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine and its pooling consumer:
// default geometry/width constants and the pooling-stage state encoding.
package conv_pkg;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_CONV_SIZE = 3;
  localparam int DEFAULT_POOL_SIZE = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_EMIT     = 2'd2,
    ST_WAIT_CLR = 2'd3
  } pool_state_t;

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of a 2x2 pooling window.
// Build option CONV_POOL_RELU_EN: when defined, every input is clamped to
// zero if negative before the max, so the result is never negative.
module pool_max4 #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] a_v, b_v, c_v, d_v;
  logic signed [DATA_W-1:0] m_ab, m_cd;

`ifdef CONV_POOL_RELU_EN
  assign a_v = a[DATA_W-1] ? '0 : a;
  assign b_v = b[DATA_W-1] ? '0 : b;
  assign c_v = c[DATA_W-1] ? '0 : c;
  assign d_v = d[DATA_W-1] ? '0 : d;
`else
  assign a_v = a;
  assign b_v = b;
  assign c_v = c;
  assign d_v = d;
`endif

  // two-level compare tree; operands are same-width signed so no overflow
  always_comb begin
    m_ab = (a_v > b_v) ? a_v : b_v;
    m_cd = (c_v > d_v) ? c_v : d_v;
    y    = (m_ab > m_cd) ? m_ab : m_cd;
  end

endmodule

// File: rtl/conv_pool_stage.sv
// Pooling stage behind the sliding-window convolution engine: drains the
// engine's result matrix, then streams a 2x2 stride-1 max-pool over a
// valid/ready port. Build option CONV_POOL_RELU_EN enables ReLU before the
// max (implemented inside pool_max4).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for conv_done
//   FETCH    | issuing conv_read strobes and capturing conv_data
//   EMIT     | presenting pooled values until the last one is accepted
//   WAIT_CLR | waiting for conv_done to drop so a held flag cannot retrigger
module conv_pool_stage
  import conv_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CONV_SIZE = DEFAULT_CONV_SIZE,
  parameter int POOL_SIZE = DEFAULT_POOL_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conv_done,
  output logic              conv_read,
  input  logic [DATA_W-1:0] conv_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int OUT_SIZE = CONV_SIZE - POOL_SIZE + 1;
  localparam int NUM_CONV = CONV_SIZE * CONV_SIZE;
  localparam int CNT_W    = $clog2(NUM_CONV + 1);
  localparam int IDX_W    = $clog2(NUM_CONV);
  localparam int POS_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  pool_state_t              state_q;
  logic [CNT_W-1:0]         issue_cnt_q;
  logic [IDX_W-1:0]         cap_cnt_q;
  logic                     read_d_q;
  logic [POS_W-1:0]         pr_q;
  logic [POS_W-1:0]         pc_q;
  logic signed [DATA_W-1:0] conv_buf [NUM_CONV];

  logic                     capture;
  logic                     cap_last;
  logic                     handshake;
  logic                     pc_wrap;
  logic                     last_pos;
  logic [IDX_W-1:0]         idx_tl, idx_tr, idx_bl, idx_br;
  logic signed [DATA_W-1:0] max_val;

  // issue counter runs down from NUM_CONV; strobe while it is non-zero
  assign conv_read = (state_q == ST_FETCH) && (issue_cnt_q != '0);
  assign capture   = (state_q == ST_FETCH) && read_d_q;
  assign cap_last  = capture && (cap_cnt_q == IDX_W'(NUM_CONV - 1));

  assign out_valid = (state_q == ST_EMIT);
  assign handshake = out_valid && out_ready;
  assign pc_wrap   = (pc_q == POS_W'(OUT_SIZE - 1));
  assign last_pos  = pc_wrap && (pr_q == POS_W'(OUT_SIZE - 1));
  assign out_last  = out_valid && last_pos;
  assign busy      = (state_q != ST_IDLE);

  assign idx_tl = IDX_W'(int'(pr_q) * CONV_SIZE + int'(pc_q));
  assign idx_tr = IDX_W'(int'(pr_q) * CONV_SIZE + int'(pc_q) + 1);
  assign idx_bl = IDX_W'((int'(pr_q) + 1) * CONV_SIZE + int'(pc_q));
  assign idx_br = IDX_W'((int'(pr_q) + 1) * CONV_SIZE + int'(pc_q) + 1);

  pool_max4 #(
    .DATA_W (DATA_W)
  ) u_pool_max4 (
    .a (conv_buf[idx_tl]),
    .b (conv_buf[idx_tr]),
    .c (conv_buf[idx_bl]),
    .d (conv_buf[idx_br]),
    .y (max_val)
  );

  assign out_data = out_valid ? max_val : '0;

  // result buffer needs no reset: it is always fully rewritten before EMIT
  always_ff @(posedge clk) begin
    if (capture) begin
      conv_buf[cap_cnt_q] <= conv_data;
    end
  end

  // sequencing FSM with issue/capture counters and output index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      read_d_q    <= 1'b0;
      pr_q        <= '0;
      pc_q        <= '0;
    end else begin
      read_d_q <= conv_read;
      case (state_q)
        ST_IDLE: begin
          if (conv_done) begin
            state_q     <= ST_FETCH;
            issue_cnt_q <= CNT_W'(NUM_CONV);
            cap_cnt_q   <= '0;
          end
        end
        ST_FETCH: begin
          if (conv_read) begin
            issue_cnt_q <= issue_cnt_q - CNT_W'(1);
          end
          if (capture) begin
            cap_cnt_q <= cap_cnt_q + IDX_W'(1);
          end
          if (cap_last) begin
            state_q <= ST_EMIT;
            pr_q    <= '0;
            pc_q    <= '0;
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            if (last_pos) begin
              state_q <= ST_WAIT_CLR;
            end else if (pc_wrap) begin
              pc_q <= '0;
              pr_q <= pr_q + POS_W'(1);
            end else begin
              pc_q <= pc_q + POS_W'(1);
            end
          end
        end
        ST_WAIT_CLR: begin
          if (!conv_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_stage.sv
// Directed bench for conv_pool_stage with a simple upstream engine model.
// Expected pooled values follow the CONV_POOL_RELU_EN build option.
module tb_conv_pool_stage;

  typedef int mat_t [9];

  logic        clk = 1'b0;
  logic        reset;
  logic        conv_done;
  logic        conv_read;
  logic [31:0] conv_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  mat_t mem;
  int   rd_idx;
  int   read_cnt;
  logic up_clr;

  conv_pool_stage u_dut (
    .clk       (clk),
    .reset     (reset),
    .conv_done (conv_done),
    .conv_read (conv_read),
    .conv_data (conv_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // upstream engine: registered read port, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (!reset || up_clr) begin
      rd_idx    <= 0;
      read_cnt  <= 0;
      conv_data <= '0;
    end else if (conv_read) begin
      conv_data <= (rd_idx < 9) ? 32'(mem[rd_idx]) : 32'hdead_beef;
      rd_idx    <= rd_idx + 1;
      read_cnt  <= read_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic run(input string tag, input mat_t m, input int e0, input int e1,
                     input int e2, input int e3, input int stall_beat);
    int exp_q [4];
    int lat;
    exp_q     = '{e0, e1, e2, e3};
    conv_done = 1'b0;
    up_clr    = 1'b1;
    mem       = m;
    @(negedge clk);
    up_clr = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    out_ready = 1'b1;
    conv_done = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd11);
    for (int b = 0; b < 4; b++) begin
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          chk({tag, "_stall_data"}, out_data, 32'(exp_q[b]));
        end
        out_ready = 1'b1;
      end
      chk({tag, "_data"}, out_data, 32'(exp_q[b]));
      chk({tag, "_last"}, 32'(out_last), 32'(b == 3));
      @(negedge clk);
    end
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_data"}, out_data, 32'd0);
    repeat (5) @(negedge clk);
    chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    chk({tag, "_reads"}, 32'(read_cnt), 32'd9);
  endtask

  initial begin
    reset     = 1'b0;
    conv_done = 1'b0;
    out_ready = 1'b1;
    up_clr    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_conv_read", 32'(conv_read), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run("basic", '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 5, 6, 8, 9, -1);
`ifdef CONV_POOL_RELU_EN
    run("neg", '{-5, -5, -5, -5, -5, -5, -5, -5, -5}, 0, 0, 0, 0, -1);
`else
    run("neg", '{-5, -5, -5, -5, -5, -5, -5, -5, -5}, -5, -5, -5, -5, -1);
`endif
    run("mixed", '{-1, -2, -3, -4, 7, -6, -7, -8, -9}, 7, 7, 7, 7, -1);
    run("bp", '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 5, 6, 8, 9, 1);
    run("asym", '{9, -3, 2, 0, 4, 11, -8, 6, 1}, 9, 11, 6, 11, -1);

    // reset asserted in the fourth read cycle of a fetch
    conv_done = 1'b0;
    @(negedge clk);
    conv_done = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_conv_read", 32'(conv_read), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_conv_read", 32'(conv_read), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    conv_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("after_rst", '{3, 1, 4, 1, 5, 9, 2, 6, 5}, 5, 9, 6, 9, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pool_stage.md
# conv_pool_stage

Downstream consumer of the 3x3-kernel sliding-window convolution engine. It waits for the engine's completion flag, drains the engine's 3x3 result matrix through the `read`/`data_out` port, optionally applies ReLU, and performs a 2x2 stride-1 max-pool. The resulting 2x2 feature map is streamed out over a valid/ready interface to the next layer or the host.

## Interface
- `DATA_W`, 32: width of convolution results and pooled outputs, signed two's complement.
- `CONV_SIZE`, 3: side length of the incoming convolution output matrix.
- `POOL_SIZE`, 2: pooling window side, stride 1.
- `OUT_SIZE`, `CONV_SIZE-POOL_SIZE+1` = 2: side length of the pooled output matrix.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `conv_done` input 1: level from the upstream engine; high means its result matrix is readable.
- `conv_read` output 1: read strobe to the upstream engine; one result requested per high cycle.
- `conv_data` input DATA_W: upstream result, valid the cycle after the corresponding `conv_read`.
- `out_valid` output 1: a pooled value is presented.
- `out_ready` input 1: downstream accepts when high together with `out_valid`.
- `out_data` output DATA_W: pooled value, row-major order.
- `out_last` output 1: marks the final (OUT_SIZE²-th) pooled value.
- `busy` output 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, FETCH, EMIT, WAIT_CLR.
- **IDLE**
  - `conv_done` high → FETCH.
- **FETCH**
  - `conv_read` is high for exactly CONV_SIZE² consecutive cycles, counted by the issue counter.
  - A 1-cycle delayed copy of `conv_read` enables capture of `conv_data` into a CONV_SIZE×CONV_SIZE buffer, row-major, using the capture counter.
  - After the CONV_SIZE²-th capture → EMIT.
- **EMIT**
  - Output index (pr, pc) starts at (0,0).
  - `out_data` = signed max of buf[pr][pc], buf[pr][pc+1], buf[pr+1][pc], buf[pr+1][pc+1], with each value passed through ReLU when configured (see Configuration).
  - A handshake (`out_valid && out_ready`) advances pc, wrapping to 0 and incrementing pr at OUT_SIZE-1.
  - A handshake with `out_last` high → WAIT_CLR.
- **WAIT_CLR**
  - `conv_done` low → IDLE.
  - Prevents the level-held upstream flag from retriggering a second fetch.
- **Arithmetic**
  - All comparisons are signed DATA_W.
  - No widening and no saturation; max cannot overflow.

## Timing
- **Reset values:** `conv_read`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. The FSM returns to IDLE and all counters clear. Buffer contents are don't-care.
- **Fetch sequence:**
  - `conv_done` sampled high at edge N → `conv_read` high on cycles N+1..N+9.
  - Captures occur at edges N+2..N+10.
  - `out_valid` rises in cycle N+11.
- **Output latency:** minimum 11 cycles from the `conv_done` sample to the first `out_valid`. With `out_ready` held high, the last beat is accepted 3 cycles later.
- **Output stability:** `out_data`/`out_last` are combinational from registered buffer and index. They are stable while `out_valid` is high and unaccepted. `out_data` is forced to 0 when `out_valid` is low.
- **Backpressure:** `out_valid` never drops without a handshake; the index is held.
- **`conv_done` changes:** a fall during FETCH or EMIT is ignored and the transfer completes.
- **Reset mid-operation:** immediately aborts with all outputs at reset values. A partially drained upstream is not recovered by this block.

## Configuration
- `CONV_POOL_RELU_EN`
  - Defined: each buffered value is clamped as `v<0 ? 0 : v` before the max, so outputs are ≥0.
  - Undefined: raw signed max; negative outputs are possible.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum `pool_state_t`.
  - Default `DATA_W`, `CONV_SIZE`, `POOL_SIZE` constants, shared with the convolution engine.
- One sub-module `pool_max4`: combinational signed 4-input max, with ReLU conditional on `CONV_POOL_RELU_EN`.

## Test plan
- **Basic pooling:** upstream matrix 1..9 row-major, `out_ready`=1 → outputs 5,6,8,9; `out_last` only on 9; exactly 9 `conv_read` cycles.
- **Negative values:** all -5 → with `CONV_POOL_RELU_EN` outputs 0,0,0,0; without it, -5 ×4.
- **Mixed signs:** matrix {-1,-2,-3; -4,7,-6; -7,-8,-9} → 7,7,7,7 in both builds.
- **Backpressure:** `out_ready` low for 3 cycles at beat 2 → `out_data`=6 held, `out_valid` held high, no index advance.
- **Level-held flag:** `conv_done` held high after completion → no second FETCH. Drive it low 1 cycle, then high → a new FETCH starts.
- **Reset mid-fetch:** `reset` low during FETCH cycle 4 → all outputs 0 and IDLE. The next `conv_done` starts a fresh 9-read fetch.
